// File: rtl/bus_defs.sv
// Shared definitions for the bus cycle controller.
//   ACTIVE / INACTIVE  : levels of the active-low bus strobes
//   PORT_*             : port-size codes, identical to the DSACK encoding
//   bus_state_e        : cycle FSM states
//   idx_width()        : width of a region index
//   ack_code()         : DSACK level returned for a latched port code
package bus_defs;

  localparam logic ACTIVE   = 1'b0;
  localparam logic INACTIVE = 1'b1;

  localparam logic [1:0] PORT_32  = 2'b00;
  localparam logic [1:0] PORT_16  = 2'b01;
  localparam logic [1:0] PORT_8   = 2'b10;
  localparam logic [1:0] PORT_EXT = 2'b11;

  localparam logic [1:0] DSACK_NONE   = 2'b11;
  localparam logic [2:0] FC_CPU_SPACE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10,
    ST_BERR = 2'b11
  } bus_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Externally acknowledged ports complete as a 32-bit transfer.
  function automatic logic [1:0] ack_code(input logic [1:0] port);
    case (port)
      PORT_32:  return PORT_32;
      PORT_16:  return PORT_16;
      PORT_8:   return PORT_8;
      default:  return PORT_32;
    endcase
  endfunction

endpackage

// File: rtl/region_decode.sv
// Combinational address-region decoder.
//   addr_i : decoded CPU address bits
//   hit_o  : at least one region matches
//   idx_o  : index of the lowest-numbered matching region (0 when no hit)
// Region r matches when (addr_i & REGION_MASK[r]) == REGION_MATCH[r].
module region_decode
  import bus_defs::*;
#(
  parameter int unsigned                   REGIONS      = 4,
  parameter int unsigned                   ADDR_BITS    = 5,
  parameter logic [REGIONS*ADDR_BITS-1:0]  REGION_MATCH = '0,
  parameter logic [REGIONS*ADDR_BITS-1:0]  REGION_MASK  = '0,
  parameter int unsigned                   IDX_W        = idx_width(REGIONS)
) (
  input  logic [ADDR_BITS-1:0] addr_i,
  output logic                 hit_o,
  output logic [IDX_W-1:0]     idx_o
);

  logic found;

  always_comb begin
    found = 1'b0;
    idx_o = '0;
    for (int unsigned r = 0; r < REGIONS; r++) begin
      if (!found &&
          ((addr_i & REGION_MASK[r*ADDR_BITS +: ADDR_BITS]) ==
           REGION_MATCH[r*ADDR_BITS +: ADDR_BITS])) begin
        found = 1'b1;
        idx_o = IDX_W'(r);
      end
    end
    hit_o = found;
  end

endmodule

// File: rtl/bus_cycle_controller.sv
// CPU bus cycle controller: decodes the address into active-low region
// selects, inserts per-region wait states and returns DSACK (port size)
// or BERR (no region).
//   clock, reset  : system clock, asynchronous active-high reset
//   cpu_as        : address strobe (active low)
//   cpu_fc        : function code; 3'b111 (CPU space) is ignored here
//   cpu_address   : decoded address bits
//   region_ready  : active-low ready, used by externally acked regions
//   request       : active-low region selects (combinational)
//   cpu_dsack     : active-low size acknowledge
//   cpu_berr      : active-low bus error
//   busy          : FSM not idle
// Build option: define BUS_TIMEOUT_EN to add a watchdog that turns a
// WAIT lasting TIMEOUT_CYCLES clocks into a bus error.
module bus_cycle_controller
  import bus_defs::*;
#(
  parameter int unsigned                    REGIONS        = 4,
  parameter int unsigned                    ADDR_BITS      = 5,
  parameter int unsigned                    WAIT_WIDTH     = 4,
  parameter logic [REGIONS*ADDR_BITS-1:0]   REGION_MATCH   = '0,
  parameter logic [REGIONS*ADDR_BITS-1:0]   REGION_MASK    = '0,
  parameter logic [REGIONS*WAIT_WIDTH-1:0]  REGION_WAITS   = '0,
  parameter logic [REGIONS*2-1:0]           REGION_PORT    = '0,
  parameter int unsigned                    TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cpu_as,
  input  logic [2:0]           cpu_fc,
  input  logic [ADDR_BITS-1:0] cpu_address,
  input  logic [REGIONS-1:0]   region_ready,
  output logic [REGIONS-1:0]   request,
  output logic [1:0]           cpu_dsack,
  output logic                 cpu_berr,
  output logic                 busy
);

  localparam int unsigned IDX_W = idx_width(REGIONS);

  if (REGIONS < 1 || REGIONS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("bus_cycle_controller: REGIONS must be 1..8 and TIMEOUT_CYCLES >= 1");
  end

  logic                  hit;
  logic [IDX_W-1:0]      hit_idx;
  logic                  cycle_start;
  logic [WAIT_WIDTH-1:0] sel_waits;
  logic [1:0]            sel_port;
  logic                  wait_done;
  logic                  wd_expired;

  bus_state_e            state_q, state_d;
  logic [WAIT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [IDX_W-1:0]      region_q, region_d;
  logic [1:0]            port_q, port_d;

  region_decode #(
    .REGIONS      (REGIONS),
    .ADDR_BITS    (ADDR_BITS),
    .REGION_MATCH (REGION_MATCH),
    .REGION_MASK  (REGION_MASK),
    .IDX_W        (IDX_W)
  ) u_decode (
    .addr_i (cpu_address),
    .hit_o  (hit),
    .idx_o  (hit_idx)
  );

  assign cycle_start = (cpu_as == ACTIVE) && (cpu_fc != FC_CPU_SPACE);
  assign sel_waits   = REGION_WAITS[int'(hit_idx)*WAIT_WIDTH +: WAIT_WIDTH];
  assign sel_port    = REGION_PORT[int'(hit_idx)*2 +: 2];

  // The first WAIT edge already counts as a wait state, so the count is
  // finished once it is about to step from 1 to 0; this yields DSACK N+1
  // edges after AS is first sampled low.
  assign wait_done = (wcnt_q <= WAIT_WIDTH'(1));

  always_comb begin
    request = '1;
    if (cycle_start && hit) begin
      request[hit_idx] = ACTIVE;
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_q, wd_d;

  assign wd_expired = (state_q == ST_WAIT) && (wd_q >= WD_LIMIT);

  always_comb begin
    wd_d = wd_q;
    if (state_q == ST_IDLE) begin
      wd_d = '0;
    end else if (state_q == ST_WAIT) begin
      wd_d = wd_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= '0;
      region_q <= '0;
      port_q   <= PORT_32;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      region_q <= region_d;
      port_q   <= port_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    region_d = region_q;
    port_d   = port_q;
    case (state_q)
      ST_IDLE: begin
        if (cycle_start) begin
          if (!hit) begin
            state_d = ST_BERR;
          end else begin
            region_d = hit_idx;
            port_d   = sel_port;
            if (sel_waits == '0 && sel_port != PORT_EXT) begin
              state_d = ST_ACK;
            end else begin
              state_d = ST_WAIT;
              wcnt_d  = sel_waits;
            end
          end
        end
      end
      ST_WAIT: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - WAIT_WIDTH'(1);
        end
        if (cpu_as == INACTIVE) begin
          state_d = ST_IDLE;
          wcnt_d  = '0;
        end else if (wd_expired) begin
          state_d = ST_BERR;
        end else if (wait_done &&
                     (port_q != PORT_EXT || region_ready[region_q] == ACTIVE)) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK, ST_BERR: begin
        if (cpu_as == INACTIVE) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Responses are gated by AS so they drop in the same cycle AS rises.
  always_comb begin
    cpu_dsack = DSACK_NONE;
    cpu_berr  = INACTIVE;
    busy      = (state_q != ST_IDLE);
    if (cpu_as == ACTIVE) begin
      case (state_q)
        ST_ACK:  cpu_dsack = ack_code(port_q);
        ST_BERR: cpu_berr  = ACTIVE;
        default: ;
      endcase
    end
  end

endmodule
